// File: rtl/divmul_pkg.sv
// Shared types and constants for the multiply/divide datapath.
package divmul_pkg;

   localparam int unsigned DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Quotient reported for a zero divisor (all ones at the default width)
   localparam logic [2*DEFAULT_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Request/response handshake bundle for the sequential restoring divider.
interface seq_restoring_divider_if #(
   parameter int unsigned WIDTH = divmul_pkg::DEFAULT_WIDTH
);
   logic               in_valid;
   logic               in_ready;
   logic [2*WIDTH-1:0] dividend;
   logic [WIDTH-1:0]   divisor;
   logic               out_valid;
   logic               out_ready;
   logic [2*WIDTH-1:0] quotient;
   logic [WIDTH-1:0]   remainder;
   logic               div_by_zero;

   modport master (
      output in_valid, dividend, divisor, out_ready,
      input  in_ready, out_valid, quotient, remainder, div_by_zero
   );

   modport slave (
      input  in_valid, dividend, divisor, out_ready,
      output in_ready, out_valid, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/seq_restoring_divider_div_step.sv
// One combinational restoring-division iteration: shift in a dividend bit, trial-subtract.
module div_step #(
   parameter int unsigned WIDTH = divmul_pkg::DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] rem,
   input  logic             dvd_bit,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic             q_bit
);

   localparam int unsigned TW = WIDTH + 1;

   logic [TW-1:0] trial;
   logic [TW-1:0] diff;

   // A restored remainder is always below divisor, so it fits back into WIDTH bits
   always_comb begin
      trial    = {rem, dvd_bit};
      diff     = trial - {1'b0, divisor};
      q_bit    = (trial >= {1'b0, divisor});
      rem_next = q_bit ? WIDTH'(diff) : WIDTH'(trial);
   end

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Optional DIV_EARLY_EXIT_EN: skip iteration when dividend < divisor.
module seq_restoring_divider
   import divmul_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input logic                    clk,
   input logic                    rst_n,
   seq_restoring_divider_if.slave bus
);

   localparam int unsigned DW    = 2 * WIDTH;
   localparam int unsigned CNT_W = $clog2(2 * WIDTH + 1);

   state_t            state_q;
   logic [DW-1:0]     dvd_q;
   logic [WIDTH-1:0]  dvs_q;
   logic [WIDTH-1:0]  rem_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              in_ready_q;
   logic              out_valid_q;
   logic [DW-1:0]     quotient_q;
   logic [WIDTH-1:0]  remainder_q;
   logic              div_by_zero_q;

   logic [WIDTH-1:0]  step_rem;
   logic              step_q;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem_q),
      .dvd_bit  (dvd_q[DW-1]),
      .divisor  (dvs_q),
      .rem_next (step_rem),
      .q_bit    (step_q)
   );

   // Control and datapath; quotient bits fill the dividend register from the LSB
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         dvd_q         <= '0;
         dvs_q         <= '0;
         rem_q         <= '0;
         cnt_q         <= '0;
         in_ready_q    <= 1'b1;
         out_valid_q   <= 1'b0;
         quotient_q    <= '0;
         remainder_q   <= '0;
         div_by_zero_q <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  dvd_q      <= bus.dividend;
                  dvs_q      <= bus.divisor;
                  rem_q      <= '0;
                  cnt_q      <= CNT_W'(DW);
                  in_ready_q <= 1'b0;
                  if (bus.divisor == '0) begin
                     state_q       <= DONE;
                     out_valid_q   <= 1'b1;
                     quotient_q    <= {DW{DIV_ZERO_QUOTIENT[0]}};
                     remainder_q   <= '0;
                     div_by_zero_q <= 1'b1;
                  end
`ifdef DIV_EARLY_EXIT_EN
                  else if (bus.dividend < {{WIDTH{1'b0}}, bus.divisor}) begin
                     state_q       <= DONE;
                     out_valid_q   <= 1'b1;
                     quotient_q    <= '0;
                     remainder_q   <= bus.dividend[WIDTH-1:0];
                     div_by_zero_q <= 1'b0;
                  end
`endif
                  else begin
                     state_q       <= CALC;
                     div_by_zero_q <= 1'b0;
                  end
               end
            end

            CALC: begin
               rem_q <= step_rem;
               dvd_q <= {dvd_q[DW-2:0], step_q};
               cnt_q <= cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_q     <= DONE;
                  out_valid_q <= 1'b1;
                  quotient_q  <= {dvd_q[DW-2:0], step_q};
                  remainder_q <= step_rem;
               end
            end

            DONE: begin
               if (bus.out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end

            default: begin
               state_q     <= IDLE;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
            end
         endcase
      end
   end

   assign bus.in_ready    = in_ready_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.quotient    = quotient_q;
   assign bus.remainder   = remainder_q;
   assign bus.div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed bench for seq_restoring_divider; honours DIV_EARLY_EXIT_EN for latency expectations.
module tb_seq_restoring_divider;

   localparam int unsigned WIDTH = 4;
   localparam int unsigned MAX_WAIT = 50;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;

   seq_restoring_divider_if #(.WIDTH(WIDTH)) bus ();

   seq_restoring_divider #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one operation for exactly one acceptance edge
   task automatic start_op(input logic [7:0] dvd, input logic [3:0] dvs);
      check("accept_ready", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.dividend = dvd;
      bus.divisor  = dvs;
      tick();
      bus.in_valid = 1'b0;
   endtask

   // Latency counts the acceptance edge as cycle 1
   task automatic wait_result(output int lat);
      lat = 1;
      while (bus.out_valid !== 1'b1 && lat < MAX_WAIT) begin
         tick();
         lat++;
      end
   endtask

   task automatic run_op(input string tag, input logic [7:0] dvd, input logic [3:0] dvs,
                         input logic [7:0] exp_q, input logic [3:0] exp_r,
                         input logic exp_z, input int exp_lat);
      int lat;
      start_op(dvd, dvs);
      if (exp_lat > 1) check({tag, "_busy"}, 32'(bus.in_ready), 32'd0);
      wait_result(lat);
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "_quotient"}, 32'(bus.quotient), 32'(exp_q));
      check({tag, "_remainder"}, 32'(bus.remainder), 32'(exp_r));
      check({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(exp_z));
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check({tag, "_drop_valid"}, 32'(bus.out_valid), 32'd0);
   endtask

   initial begin
      int lat;
      int early_lat;
      logic stable;

      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus.in_valid  = 1'b0;
      bus.dividend  = '0;
      bus.divisor   = '0;
      bus.out_ready = 1'b0;
`ifdef DIV_EARLY_EXIT_EN
      early_lat = 1;
`else
      early_lat = 9;
`endif

      #12;
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_quotient", 32'(bus.quotient), 32'd0);
      check("rst_remainder", 32'(bus.remainder), 32'd0);
      check("rst_dbz", 32'(bus.div_by_zero), 32'd0);
      rst_n = 1'b1;
      tick();

      run_op("e1_f", 8'hE1, 4'hF, 8'h0F, 4'h0, 1'b0, 9);
      run_op("64_7", 8'h64, 4'h7, 8'h0E, 4'h2, 1'b0, 9);
      run_op("ff_1", 8'hFF, 4'h1, 8'hFF, 4'h0, 1'b0, 9);
      run_op("3c_0", 8'h3C, 4'h0, 8'hFF, 4'h0, 1'b1, 1);
      run_op("fe_3", 8'hFE, 4'h3, 8'h54, 4'h2, 1'b0, 9);

      // Result held under back-pressure while input pulses are ignored
      start_op(8'hC8, 4'hD);
      wait_result(lat);
      check("hold_latency", 32'(lat), 32'd9);
      stable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         bus.in_valid = i[0];
         bus.dividend = 8'($urandom);
         bus.divisor  = 4'($urandom);
         tick();
         if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.quotient !== 8'h0F ||
             bus.remainder !== 4'h5 || bus.div_by_zero !== 1'b0)
            stable = 1'b0;
      end
      bus.in_valid = 1'b0;
      check("hold_stable", 32'(stable), 32'd1);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("hold_release_valid", 32'(bus.out_valid), 32'd0);
      run_op("ff_f", 8'hFF, 4'hF, 8'h11, 4'h0, 1'b0, 9);

      // Abort in the middle of iteration
      start_op(8'h64, 4'h7);
      repeat (4) tick();
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", 32'(bus.out_valid), 32'd0);
      check("abort_in_ready", 32'(bus.in_ready), 32'd1);
      check("abort_quotient", 32'(bus.quotient), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      check("post_abort_valid", 32'(bus.out_valid), 32'd0);
      run_op("51_9", 8'h51, 4'h9, 8'h09, 4'h0, 1'b0, 9);

      run_op("05_9", 8'h05, 4'h9, 8'h00, 4'h5, 1'b0, early_lat);
      run_op("0e_f", 8'h0E, 4'hF, 8'h00, 4'hE, 1'b0, early_lat);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
